// File: rtl/ysyx_24080006_lsu_axi.sv
// Load/store unit: executes one latched memory request as a single AXI4-Lite
// read or write, then returns extended load data or store completion.
module ysyx_24080006_lsu_axi #(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        exu2lsu_valid,
  output logic        lsu2exu_ready,
  input  logic [31:0] lsu_addr,
  input  logic [1:0]  lsu_size,
  input  logic        lsu_sext,
  input  logic        lsu_write,
  input  logic [31:0] lsu_wdata,
  output logic        lsu2exu_valid,
  output logic [31:0] lsu_rdata,
  output logic        lsu_err,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  localparam int unsigned CNT_W = 32;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_RESP = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t           state;
  logic [1:0]       req_off;
  logic [1:0]       req_size;
  logic             req_sext;
  logic [CNT_W-1:0] tcnt;

  logic             misaligned_c;
  logic [31:0]      shifted_c;
  logic [31:0]      load_ext_c;
  logic [31:0]      wdata_c;
  logic [3:0]       wstrb_c;
  logic             tmo_c;
  logic             aw_ok_c;
  logic             w_ok_c;

  // Alignment check on the incoming request.
  always_comb begin
    misaligned_c = 1'b0;
    case (lsu_size)
      2'd0:    misaligned_c = 1'b0;
      2'd1:    misaligned_c = lsu_addr[0];
      2'd2:    misaligned_c = |lsu_addr[1:0];
      default: misaligned_c = 1'b1;
    endcase
  end

  // Lane steering and strobe generation for stores.
  always_comb begin
    wdata_c = lsu_wdata << {lsu_addr[1:0], 3'b000};
    case (lsu_size)
      2'd0:    wstrb_c = 4'b0001;
      2'd1:    wstrb_c = 4'b0011;
      default: wstrb_c = 4'b1111;
    endcase
    wstrb_c = wstrb_c << lsu_addr[1:0];
  end

  // Load data alignment and sign/zero extension.
  always_comb begin
    shifted_c = rdata >> {req_off, 3'b000};
    case (req_size)
      2'd0:    load_ext_c = {{24{req_sext & shifted_c[7]}}, shifted_c[7:0]};
      2'd1:    load_ext_c = {{16{req_sext & shifted_c[15]}}, shifted_c[15:0]};
      default: load_ext_c = shifted_c;
    endcase
  end

  // Handshake completion and timeout detection; progress wins over timeout.
  always_comb begin
    aw_ok_c = !awvalid || awready;
    w_ok_c  = !wvalid || wready;
    tmo_c   = (TIMEOUT_CYCLES != 0) && ((tcnt + CNT_W'(1)) == CNT_W'(TIMEOUT_CYCLES));
  end

  // Control FSM with registered bus and completion outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= S_IDLE;
      lsu2exu_ready <= 1'b1;
      lsu2exu_valid <= 1'b0;
      lsu_rdata     <= 32'd0;
      lsu_err       <= 1'b0;
      araddr        <= 32'd0;
      arsize        <= 3'd0;
      arvalid       <= 1'b0;
      rready        <= 1'b0;
      awaddr        <= 32'd0;
      awsize        <= 3'd0;
      awvalid       <= 1'b0;
      wdata         <= 32'd0;
      wstrb         <= 4'd0;
      wvalid        <= 1'b0;
      bready        <= 1'b0;
      req_off       <= 2'd0;
      req_size      <= 2'd0;
      req_sext      <= 1'b0;
      tcnt          <= '0;
    end else begin
      lsu2exu_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (exu2lsu_valid) begin
            req_off       <= lsu_addr[1:0];
            req_size      <= lsu_size;
            req_sext      <= lsu_sext;
            lsu2exu_ready <= 1'b0;
            tcnt          <= '0;
            if (misaligned_c) begin
              state         <= S_DONE;
              lsu2exu_valid <= 1'b1;
              lsu_err       <= 1'b1;
              lsu_rdata     <= 32'd0;
            end else if (lsu_write) begin
              state   <= S_WR_REQ;
              awaddr  <= lsu_addr;
              awsize  <= {1'b0, lsu_size};
              awvalid <= 1'b1;
              wdata   <= wdata_c;
              wstrb   <= wstrb_c;
              wvalid  <= 1'b1;
            end else begin
              state   <= S_RD_ADDR;
              araddr  <= lsu_addr;
              arsize  <= {1'b0, lsu_size};
              arvalid <= 1'b1;
            end
          end
        end
        S_RD_ADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            tcnt    <= '0;
            state   <= S_RD_DATA;
          end else if (tmo_c) begin
            arvalid       <= 1'b0;
            state         <= S_DONE;
            lsu2exu_valid <= 1'b1;
            lsu_err       <= 1'b1;
            lsu_rdata     <= 32'd0;
          end else begin
            tcnt <= tcnt + CNT_W'(1);
          end
        end
        S_RD_DATA: begin
          if (rvalid) begin
            rready        <= 1'b0;
            state         <= S_DONE;
            lsu2exu_valid <= 1'b1;
            lsu_err       <= (rresp != 2'b00);
            lsu_rdata     <= (rresp != 2'b00) ? 32'd0 : load_ext_c;
          end else if (tmo_c) begin
            rready        <= 1'b0;
            state         <= S_DONE;
            lsu2exu_valid <= 1'b1;
            lsu_err       <= 1'b1;
            lsu_rdata     <= 32'd0;
          end else begin
            tcnt <= tcnt + CNT_W'(1);
          end
        end
        S_WR_REQ: begin
          if (awready) awvalid <= 1'b0;
          if (wready)  wvalid  <= 1'b0;
          if (aw_ok_c && w_ok_c) begin
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            bready  <= 1'b1;
            tcnt    <= '0;
            state   <= S_WR_RESP;
          end else if (tmo_c) begin
            awvalid       <= 1'b0;
            wvalid        <= 1'b0;
            state         <= S_DONE;
            lsu2exu_valid <= 1'b1;
            lsu_err       <= 1'b1;
            lsu_rdata     <= 32'd0;
          end else begin
            tcnt <= tcnt + CNT_W'(1);
          end
        end
        S_WR_RESP: begin
          if (bvalid) begin
            bready        <= 1'b0;
            state         <= S_DONE;
            lsu2exu_valid <= 1'b1;
            lsu_err       <= (bresp != 2'b00);
            lsu_rdata     <= 32'd0;
          end else if (tmo_c) begin
            bready        <= 1'b0;
            state         <= S_DONE;
            lsu2exu_valid <= 1'b1;
            lsu_err       <= 1'b1;
            lsu_rdata     <= 32'd0;
          end else begin
            tcnt <= tcnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          state         <= S_IDLE;
          lsu2exu_ready <= 1'b1;
        end
        default: begin
          state         <= S_IDLE;
          lsu2exu_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24080006_lsu_axi.sv
// Self-checking bench for the AXI load/store unit with a scripted slave.
module tb_ysyx_24080006_lsu_axi;

  localparam int MAX_CYC = 40;

  logic        clock, reset;
  logic        exu2lsu_valid, lsu2exu_ready;
  logic [31:0] lsu_addr;
  logic [1:0]  lsu_size;
  logic        lsu_sext, lsu_write;
  logic [31:0] lsu_wdata;
  logic        lsu2exu_valid;
  logic [31:0] lsu_rdata;
  logic        lsu_err;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  int n_checks = 0;
  int n_fail   = 0;

  // Observations from the last transaction
  int          o_lat, o_proto, o_ar_cyc, o_aw_cyc, o_w_cyc;
  logic [31:0] o_rdata, o_araddr, o_awaddr, o_wdata, o_post_rdata;
  logic [2:0]  o_arsize, o_awsize;
  logic [3:0]  o_wstrb;
  logic        o_err, o_post_ready, o_post_valid, o_post_err;

  ysyx_24080006_lsu_axi #(.TIMEOUT_CYCLES(8)) dut (
    .clock(clock), .reset(reset),
    .exu2lsu_valid(exu2lsu_valid), .lsu2exu_ready(lsu2exu_ready),
    .lsu_addr(lsu_addr), .lsu_size(lsu_size), .lsu_sext(lsu_sext),
    .lsu_write(lsu_write), .lsu_wdata(lsu_wdata),
    .lsu2exu_valid(lsu2exu_valid), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
    .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model
  function automatic bit m_mis(input logic [31:0] a, input logic [1:0] sz);
    return (sz == 2'd3) || ((a % (32'd1 << sz)) != 0);
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] sz,
                                         input logic sx, input logic [31:0] rd);
    logic [31:0] sh, v;
    sh = rd >> (8 * (a % 4));
    if (sz == 2'd0) begin
      v = sh % 256;
      if (sx && v >= 128) v = v - 256;
    end else if (sz == 2'd1) begin
      v = sh % 65536;
      if (sx && v >= 32768) v = v - 65536;
    end else begin
      v = sh;
    end
    return v;
  endfunction

  function automatic logic [3:0] m_strb(input logic [31:0] a, input logic [1:0] sz);
    logic [31:0] t;
    t = ((32'd1 << (32'd1 << sz)) - 32'd1) << (a % 4);
    return t[3:0];
  endfunction

  function automatic int m_lat(input logic [31:0] a, input logic [1:0] sz, input logic wr,
                               input int arw, input int rw, input int aww, input int ww, input int bw);
    if (m_mis(a, sz)) return 1;
    if (wr) return ((aww > ww) ? aww : ww) + bw + 3;
    return arw + rw + 3;
  endfunction

  task automatic slave_idle();
    arready = 1'b0; rvalid = 1'b0; rdata = 32'd0; rresp = 2'b00;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
  endtask

  // Issue one request and act as the bus slave with the given wait counts.
  task automatic run_txn(input logic [31:0] a, input logic [1:0] sz, input logic sx,
                         input logic wr, input logic [31:0] wd,
                         input int arw, input int rw, input int aww, input int ww, input int bw,
                         input logic [31:0] rd, input logic [1:0] rr, input logic [1:0] br,
                         input bit stall);
    int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    o_lat = -1; o_proto = 0; o_rdata = 'x; o_err = 'x;
    o_araddr = 'x; o_arsize = 'x; o_awaddr = 'x; o_awsize = 'x; o_wdata = 'x; o_wstrb = 'x;
    @(negedge clock);
    exu2lsu_valid = 1'b1; lsu_addr = a; lsu_size = sz; lsu_sext = sx;
    lsu_write = wr; lsu_wdata = wd;
    slave_idle();
    for (int cyc = 1; cyc <= MAX_CYC; cyc++) begin
      @(negedge clock);
      if (lsu2exu_valid) begin
        o_lat = cyc; o_rdata = lsu_rdata; o_err = lsu_err;
        exu2lsu_valid = 1'b0;
        slave_idle();
        break;
      end
      if (lsu2exu_ready) o_proto++;
      if (arvalid && awvalid) o_proto++;
      if (arvalid) begin
        ar_cnt++; o_araddr = araddr; o_arsize = arsize;
        if (araddr !== a) o_proto++;
      end
      if (awvalid) begin ar_cnt = ar_cnt; aw_cnt++; o_awaddr = awaddr; o_awsize = awsize; end
      if (wvalid) begin w_cnt++; o_wdata = wdata; o_wstrb = wstrb; end
      if (rready) r_cnt++;
      if (bready) b_cnt++;
      arready = arvalid && !stall && (ar_cnt > arw);
      rvalid  = rready && (r_cnt > rw);
      rdata   = rvalid ? rd : $urandom;
      rresp   = rvalid ? rr : 2'b00;
      awready = awvalid && (aw_cnt > aww);
      wready  = wvalid && (w_cnt > ww);
      bvalid  = bready && (b_cnt > bw);
      bresp   = bvalid ? br : 2'b00;
      // Requests while busy must be ignored
      exu2lsu_valid = 1'($urandom_range(0, 1));
      lsu_addr = $urandom; lsu_size = 2'($urandom_range(0, 3));
      lsu_write = 1'($urandom_range(0, 1)); lsu_wdata = $urandom;
    end
    exu2lsu_valid = 1'b0;
    slave_idle();
    o_ar_cyc = ar_cnt; o_aw_cyc = aw_cnt; o_w_cyc = w_cnt;
    @(negedge clock);
    o_post_ready = lsu2exu_ready; o_post_valid = lsu2exu_valid;
    o_post_rdata = lsu_rdata; o_post_err = lsu_err;
  endtask

  task automatic test_reset();
    reset = 1'b0; exu2lsu_valid = 1'b0; lsu_addr = 0; lsu_size = 0;
    lsu_sext = 0; lsu_write = 0; lsu_wdata = 0;
    slave_idle();
    repeat (3) @(negedge clock);
    n_checks++; if (lsu2exu_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b exp 1", lsu2exu_ready); end
    n_checks++; if ({arvalid, rready, awvalid, wvalid, bready, lsu2exu_valid} !== 6'b0) begin
      n_fail++; $display("FAIL rst_handshakes: got %b exp 000000", {arvalid, rready, awvalid, wvalid, bready, lsu2exu_valid}); end
    n_checks++; if ({lsu_rdata, lsu_err} !== 33'd0) begin n_fail++; $display("FAIL rst_result: got %h/%b exp 0/0", lsu_rdata, lsu_err); end
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_load_word();
    run_txn(32'h8000_0004, 2'd2, 1'b0, 1'b0, 32'd0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 2'b00, 2'b00, 1'b0);
    n_checks++; if (o_lat !== 3) begin n_fail++; $display("FAIL ldw_lat: got %0d exp 3", o_lat); end
    n_checks++; if (o_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ldw_rdata: got %h exp deadbeef", o_rdata); end
    n_checks++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL ldw_err: got %b exp 0", o_err); end
    n_checks++; if (o_arsize !== 3'b010) begin n_fail++; $display("FAIL ldw_arsize: got %b exp 010", o_arsize); end
    n_checks++; if (o_araddr !== 32'h8000_0004 || o_ar_cyc !== 1) begin
      n_fail++; $display("FAIL ldw_ar: got %h cyc %0d exp 80000004 cyc 1", o_araddr, o_ar_cyc); end
    n_checks++; if (o_post_ready !== 1'b1 || o_post_valid !== 1'b0 || o_post_rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL ldw_post: got rdy %b vld %b rdata %h exp 1 0 deadbeef", o_post_ready, o_post_valid, o_post_rdata); end
  endtask

  task automatic test_load_ext();
    run_txn(32'h8000_0003, 2'd0, 1'b1, 1'b0, 32'd0, 0, 0, 0, 0, 0, 32'h80112233, 2'b00, 2'b00, 1'b0);
    n_checks++; if (o_rdata !== 32'hFFFFFF80) begin n_fail++; $display("FAIL ldb_sext: got %h exp ffffff80", o_rdata); end
    run_txn(32'h8000_0003, 2'd0, 1'b0, 1'b0, 32'd0, 0, 0, 0, 0, 0, 32'h80112233, 2'b00, 2'b00, 1'b0);
    n_checks++; if (o_rdata !== 32'h00000080) begin n_fail++; $display("FAIL ldb_zext: got %h exp 00000080", o_rdata); end
    run_txn(32'h8000_0002, 2'd1, 1'b1, 1'b0, 32'd0, 1, 2, 0, 0, 0, 32'h8001_0000, 2'b00, 2'b00, 1'b0);
    n_checks++; if (o_rdata !== 32'hFFFF8001 || o_lat !== 6) begin
      n_fail++; $display("FAIL ldh_sext: got %h lat %0d exp ffff8001 lat 6", o_rdata, o_lat); end
  endtask

  task automatic test_store_half();
    run_txn(32'h8000_0002, 2'd1, 1'b0, 1'b1, 32'h0000_ABCD, 0, 0, 0, 3, 0, 32'd0, 2'b00, 2'b00, 1'b0);
    n_checks++; if (o_wdata !== 32'hABCD0000 || o_wstrb !== 4'b1100) begin
      n_fail++; $display("FAIL sth_lanes: got %h/%b exp abcd0000/1100", o_wdata, o_wstrb); end
    n_checks++; if (o_aw_cyc !== 1 || o_w_cyc !== 4) begin
      n_fail++; $display("FAIL sth_valids: got aw %0d w %0d exp aw 1 w 4", o_aw_cyc, o_w_cyc); end
    n_checks++; if (o_lat !== 6 || o_err !== 1'b0 || o_rdata !== 32'd0) begin
      n_fail++; $display("FAIL sth_done: got lat %0d err %b rdata %h exp 6 0 0", o_lat, o_err, o_rdata); end
    n_checks++; if (o_awaddr !== 32'h8000_0002 || o_awsize !== 3'b001 || o_proto !== 0) begin
      n_fail++; $display("FAIL sth_aw: got %h %b proto %0d exp 80000002 001 0", o_awaddr, o_awsize, o_proto); end
  endtask

  task automatic test_misaligned();
    run_txn(32'h8000_0001, 2'd2, 1'b0, 1'b0, 32'd0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 2'b00, 2'b00, 1'b0);
    n_checks++; if (o_lat !== 1 || o_err !== 1'b1 || o_rdata !== 32'd0 || o_ar_cyc !== 0) begin
      n_fail++; $display("FAIL mis_ldw: got lat %0d err %b rdata %h ar %0d exp 1 1 0 0", o_lat, o_err, o_rdata, o_ar_cyc); end
    run_txn(32'h8000_0003, 2'd1, 1'b0, 1'b1, 32'h1234, 0, 0, 0, 0, 0, 32'd0, 2'b00, 2'b00, 1'b0);
    n_checks++; if (o_lat !== 1 || o_err !== 1'b1 || o_rdata !== 32'd0 || o_aw_cyc !== 0 || o_w_cyc !== 0) begin
      n_fail++; $display("FAIL mis_sth: got lat %0d err %b rdata %h aw %0d exp 1 1 0 0", o_lat, o_err, o_rdata, o_aw_cyc); end
  endtask

  task automatic test_errors();
    run_txn(32'h8000_0000, 2'd2, 1'b0, 1'b0, 32'd0, 0, 0, 0, 0, 0, 32'h5555_AAAA, 2'b10, 2'b00, 1'b0);
    n_checks++; if (o_err !== 1'b1 || o_rdata !== 32'd0) begin
      n_fail++; $display("FAIL rresp_err: got err %b rdata %h exp 1 0", o_err, o_rdata); end
    run_txn(32'h8000_0010, 2'd2, 1'b0, 1'b1, 32'h1111_2222, 0, 0, 1, 0, 2, 32'd0, 2'b00, 2'b11, 1'b0);
    n_checks++; if (o_err !== 1'b1 || o_rdata !== 32'd0 || o_lat !== 6) begin
      n_fail++; $display("FAIL bresp_err: got err %b rdata %h lat %0d exp 1 0 6", o_err, o_rdata, o_lat); end
  endtask

  task automatic test_timeout();
    int late_bad;
    run_txn(32'h8000_0020, 2'd2, 1'b0, 1'b0, 32'd0, 0, 0, 0, 0, 0, 32'd0, 2'b00, 2'b00, 1'b1);
    n_checks++; if (o_ar_cyc !== 8 || o_lat !== 9) begin
      n_fail++; $display("FAIL tmo_timing: got ar %0d lat %0d exp 8 9", o_ar_cyc, o_lat); end
    n_checks++; if (o_err !== 1'b1 || o_rdata !== 32'd0) begin
      n_fail++; $display("FAIL tmo_err: got err %b rdata %h exp 1 0", o_err, o_rdata); end
    n_checks++; if (o_post_ready !== 1'b1 || o_post_valid !== 1'b0) begin
      n_fail++; $display("FAIL tmo_idle: got rdy %b vld %b exp 1 0", o_post_ready, o_post_valid); end
    // Late responses while idle must be ignored
    late_bad = 0;
    arready = 1'b1; rvalid = 1'b1; rresp = 2'b10; bvalid = 1'b1; awready = 1'b1; wready = 1'b1;
    repeat (3) begin
      @(negedge clock);
      if (lsu2exu_valid || !lsu2exu_ready || arvalid || rready) late_bad++;
    end
    slave_idle();
    n_checks++; if (late_bad !== 0) begin n_fail++; $display("FAIL tmo_late: got %0d bad cycles exp 0", late_bad); end
  endtask

  task automatic test_reset_mid();
    int stray;
    @(negedge clock);
    exu2lsu_valid = 1'b1; lsu_addr = 32'h1000_0000; lsu_size = 2'd2; lsu_write = 1'b0; lsu_sext = 1'b0;
    slave_idle();
    @(negedge clock);
    exu2lsu_valid = 1'b0;
    arready = arvalid;
    @(negedge clock);
    arready = 1'b0;
    n_checks++; if (rready !== 1'b1) begin n_fail++; $display("FAIL rmid_rready: got %b exp 1", rready); end
    reset = 1'b0;
    @(negedge clock);
    n_checks++; if ({arvalid, rready, awvalid, wvalid, bready, lsu2exu_valid} !== 6'b0 || lsu2exu_ready !== 1'b1) begin
      n_fail++; $display("FAIL rmid_clear: got %b rdy %b exp 000000 rdy 1",
                         {arvalid, rready, awvalid, wvalid, bready, lsu2exu_valid}, lsu2exu_ready); end
    reset = 1'b1;
    stray = 0;
    repeat (3) begin
      @(negedge clock);
      if (lsu2exu_valid) stray++;
    end
    n_checks++; if (stray !== 0) begin n_fail++; $display("FAIL rmid_pulse: got %0d exp 0", stray); end
    run_txn(32'h1000_0008, 2'd2, 1'b0, 1'b0, 32'd0, 0, 0, 0, 0, 0, 32'hCAFE_F00D, 2'b00, 2'b00, 1'b0);
    n_checks++; if (o_rdata !== 32'hCAFEF00D || o_lat !== 3 || o_err !== 1'b0) begin
      n_fail++; $display("FAIL rmid_after: got %h lat %0d err %b exp cafef00d 3 0", o_rdata, o_lat, o_err); end
  endtask

  task automatic test_random();
    logic [31:0] a, wd, rd, exp_rd;
    logic [1:0]  sz, rr, br;
    logic        sx, wr, exp_err, mis;
    int arw, rw, aww, ww, bw, exp_lat;
    for (int i = 0; i < 40; i++) begin
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      if (sz != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      sx = 1'($urandom_range(0, 1)); wr = 1'($urandom_range(0, 1));
      wd = $urandom; rd = $urandom;
      rr = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      br = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      arw = $urandom_range(0, 4); rw = $urandom_range(0, 4);
      aww = $urandom_range(0, 4); ww = $urandom_range(0, 4); bw = $urandom_range(0, 4);
      run_txn(a, sz, sx, wr, wd, arw, rw, aww, ww, bw, rd, rr, br, 1'b0);
      mis = m_mis(a, sz);
      exp_lat = m_lat(a, sz, wr, arw, rw, aww, ww, bw);
      if (mis) begin exp_err = 1'b1; exp_rd = 32'd0; end
      else if (wr) begin exp_err = (br != 2'b00); exp_rd = 32'd0; end
      else begin exp_err = (rr != 2'b00); exp_rd = exp_err ? 32'd0 : m_load(a, sz, sx, rd); end
      n_checks++; if (o_lat !== exp_lat || o_err !== exp_err || o_rdata !== exp_rd) begin
        n_fail++; $display("FAIL rnd%0d_result: got lat %0d err %b rdata %h exp %0d %b %h",
                           i, o_lat, o_err, o_rdata, exp_lat, exp_err, exp_rd); end
      n_checks++; if (o_proto !== 0 || o_post_ready !== 1'b1 || o_post_rdata !== exp_rd || o_post_err !== exp_err) begin
        n_fail++; $display("FAIL rnd%0d_proto: got proto %0d rdy %b hold %h/%b exp 0 1 %h/%b",
                           i, o_proto, o_post_ready, o_post_rdata, o_post_err, exp_rd, exp_err); end
      if (mis) begin
        n_checks++; if (o_ar_cyc !== 0 || o_aw_cyc !== 0 || o_w_cyc !== 0) begin
          n_fail++; $display("FAIL rnd%0d_nobus: got ar %0d aw %0d w %0d exp 0", i, o_ar_cyc, o_aw_cyc, o_w_cyc); end
      end else if (wr) begin
        n_checks++; if (o_wdata !== (wd << (8 * (a % 4))) || o_wstrb !== m_strb(a, sz) ||
                        o_awaddr !== a || o_aw_cyc !== aww + 1 || o_w_cyc !== ww + 1) begin
          n_fail++; $display("FAIL rnd%0d_store: got %h/%b addr %h aw %0d w %0d exp %h/%b %h %0d %0d",
                             i, o_wdata, o_wstrb, o_awaddr, o_aw_cyc, o_w_cyc,
                             wd << (8 * (a % 4)), m_strb(a, sz), a, aww + 1, ww + 1); end
      end else begin
        n_checks++; if (o_arsize !== {1'b0, sz} || o_ar_cyc !== arw + 1 || o_aw_cyc !== 0) begin
          n_fail++; $display("FAIL rnd%0d_load: got size %b ar %0d aw %0d exp %b %0d 0",
                             i, o_arsize, o_ar_cyc, o_aw_cyc, {1'b0, sz}, arw + 1); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_load_ext();
    test_store_half();
    test_misaligned();
    test_errors();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_24080006_lsu_axi.md
Name: ysyx_24080006_lsu_axi

Overview:
- Load/store unit directly downstream of the execute stage.
- Accepts one latched memory request per handshake: address, size, sign-extend flag, write flag and store data.
- Runs the request as a single AXI4-Lite-style read or write transaction on the data bus, then returns aligned, sign/zero-extended load data or a store completion to the execute stage.
- Handles byte-lane steering, write strobes, misalignment detection, bus error responses and an optional response timeout.

Parameters:
TIMEOUT_CYCLES, 0, cycles to wait in any bus-wait state before aborting with error; 0 disables the timeout.

Ports:
clock  in  1  system clock
reset  in  1  synchronous reset, active-low; asserted when 0
exu2lsu_valid  in  1  request valid from execute stage
lsu2exu_ready  out  1  unit can accept a request
lsu_addr  in  32  byte address
lsu_size  in  2  0=byte, 1=half, 2=word, 3=illegal
lsu_sext  in  1  sign-extend load data
lsu_write  in  1  1=store, 0=load
lsu_wdata  in  32  store data, LSB-aligned
lsu2exu_valid  out  1  one-cycle completion pulse
lsu_rdata  out  32  extended load data; 0 for stores and errors
lsu_err  out  1  qualifies lsu2exu_valid: misaligned, bus error or timeout
araddr  out  32  read address
arsize  out  3  {1'b0, lsu_size}
arvalid  out  1  read address valid
arready  in  1  read address ready
rdata  in  32  read data
rresp  in  2  read response; nonzero = error
rvalid  in  1  read data valid
rready  out  1  read data ready
awaddr  out  32  write address
awsize  out  3  {1'b0, lsu_size}
awvalid  out  1  write address valid
awready  in  1  write address ready
wdata  out  32  lane-steered store data
wstrb  out  4  byte strobes
wvalid  out  1  write data valid
wready  in  1  write data ready
bresp  in  2  write response; nonzero = error
bvalid  in  1  write response valid
bready  out  1  write response ready

Behaviour:
- Reset (reset==0 at a clock edge): state IDLE.
  - lsu2exu_ready=1.
  - All other outputs, valids and readies 0; timeout counter 0.
  - Reset mid-transaction abandons the transaction with no completion pulse; the bus slave shares the same reset.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE:
  - lsu2exu_ready=1, and 1 only in IDLE.
  - On exu2lsu_valid: latch all request fields. Misaligned (size 1 with addr[0]=1, size 2 with addr[1:0]!=0, or size 3) -> DONE with error, no bus activity. Otherwise load -> RD_ADDR, store -> WR_REQ.
- RD_ADDR: arvalid=1, araddr = latched address, held stable; on arready -> RD_DATA.
- RD_DATA:
  - rready=1.
  - On rvalid: shifted = rdata >> (8*addr[1:0]). Byte: shifted[7:0] extended by sext; half: shifted[15:0] extended by sext; word: shifted.
  - Capture result and error = (rresp!=0) -> DONE.
- WR_REQ:
  - awvalid and wvalid both rise on entry; each drops independently the cycle after its own handshake. Exit to WR_RESP once both handshakes have completed (same or different cycles).
  - wdata = lsu_wdata << (8*addr[1:0]).
  - wstrb = {0001, 0011, 1111}[size] << addr[1:0].
- WR_RESP: bready=1; on bvalid capture error = (bresp!=0) -> DONE.
- DONE:
  - lsu2exu_valid=1 for exactly one cycle; lsu_err and lsu_rdata valid that cycle.
  - lsu_rdata forced to 0 on error or store; next state IDLE.
- Completion is registered. Minimum latency with a zero-wait slave:
  - load: accept at T, arvalid at T+1, rready at T+2, pulse at T+3;
  - store: accept at T, aw/w at T+1, bready at T+2, pulse at T+3;
  - misaligned: accept at T, pulse at T+1.
- Outside DONE, lsu_rdata and lsu_err hold their last completed values.
- Timeout (TIMEOUT_CYCLES>0):
  - Counter clears on entering any bus state and increments each cycle in RD_ADDR, RD_DATA, WR_REQ or WR_RESP.
  - When it reaches TIMEOUT_CYCLES: drop all valids/readies, go to DONE with error. Late bus responses are ignored once back in IDLE.
- exu2lsu_valid while not in IDLE is ignored: ready is 0, no queueing.
- Only one outstanding transaction at any time; ar and aw are never active together.

Test Plan:
- Load word at 0x8000_0004, slave returns rdata=0xDEADBEEF, rresp=0, zero wait -> pulse at T+3, lsu_rdata=0xDEADBEEF, lsu_err=0, arsize=3'b010.
- Load byte at 0x...03 with sext=1, rdata=0x80112233 -> 0xFFFFFF80; same request with sext=0 -> 0x00000080. Load half at 0x...02 with sext=1, rdata=0x8001_0000 -> 0xFFFF8001.
- Store half 0x0000_ABCD at 0x...02 -> wdata=0xABCD0000, wstrb=4'b1100. awready arrives 3 cycles before wready; awvalid drops early, wvalid held until its handshake; bresp=0 -> pulse with err=0, rdata=0.
- Word load at 0x...01 and half store at 0x...03 -> no arvalid/awvalid ever asserted; pulse at T+1 with lsu_err=1, rdata=0.
- Error and timeout cases:
  - rresp=2'b10 on a load -> lsu_err=1, rdata=0.
  - TIMEOUT_CYCLES=8 with a slave that never asserts arready -> arvalid drops after 8 cycles, error pulse, back in IDLE with lsu2exu_ready=1.
- Reset driven low while in RD_DATA -> next cycle all valids/readies 0, lsu2exu_ready=1, no completion pulse. A new request afterwards completes normally.
